// File: rtl/decode_queue.sv
// decode_queue: registered RV32I decode stage with decoded-entry FIFO and load-use hold; `DECODE_RV32M_EN adds M-extension tagging
package control_pkg;
    typedef enum logic [3:0] {ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND} alu_op_t;
    typedef enum logic [2:0] {IMM_NONE, IMM_I, IMM_S, IMM_B, IMM_J, IMM_U} imm_type_t;
    typedef enum logic [1:0] {A_RS1, A_PC, A_ZERO} a_sel_t;
    typedef enum logic {B_RS2, B_IMM} b_sel_t;
    typedef enum logic [1:0] {WB_ALU, WB_MEM, WB_PC4} wb_sel_t;
    typedef enum logic [3:0] {BR_NONE, BR_EQ, BR_NE, BR_LT, BR_GE, BR_LTU, BR_GEU, BR_JAL, BR_JALR} br_type_t;
    typedef struct packed {
        alu_op_t   alu_op;
        logic      regwen;
        imm_type_t imm_type;
        a_sel_t    a_sel;
        b_sel_t    b_sel;
        wb_sel_t   wb_sel;
        br_type_t  br_type;
        logic      mem_read;
        logic      mem_write;
        logic [2:0] mem_funct3;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [4:0] rd;
    } control_signals_t;
    localparam control_signals_t CTRL_NOP = '0;
endpackage

module decode_queue
    import control_pkg::*;
#(
    parameter int PC_W        = 32,
    parameter int DEPTH       = 2,
    parameter int STALL_CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [31:0]            in_instr,
    input  logic [PC_W-1:0]        in_pc,
    input  logic                   flush,
    input  logic                   ex_is_load,
    input  logic [4:0]             ex_rd,
    output logic                   out_valid,
    input  logic                   out_ready,
    output control_signals_t       out_ctrl,
    output logic [31:0]            out_imm,
    output logic [PC_W-1:0]        out_pc,
    output logic                   out_illegal,
`ifdef DECODE_RV32M_EN
    output logic                   out_is_muldiv,
    output logic [2:0]             out_muldiv_op,
`endif
    output logic [STALL_CNT_W-1:0] stall_cnt
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] L_FULL = (AW+1)'(DEPTH);

    typedef struct packed {
        control_signals_t ctrl;
        logic [31:0]      imm;
        logic [PC_W-1:0]  pc;
        logic             ill;
        logic             use1;
        logic             use2;
`ifdef DECODE_RV32M_EN
        logic             md;
        logic [2:0]       md_op;
`endif
    } entry_t;

    entry_t                 r_mem [DEPTH];
    logic [AW-1:0]          r_rd_ptr;
    logic [AW-1:0]          r_wr_ptr;
    logic [AW:0]            r_count;
    logic [STALL_CNT_W-1:0] r_stall;

    control_signals_t w_dec;
    entry_t           w_in;
    entry_t           w_head;
    logic [31:0]      w_imm;
    logic [6:0]       w_opc;
    logic [2:0]       w_f3;
    logic [6:0]       w_f7;
    logic             w_bad;
    logic             w_use1;
    logic             w_use2;
    logic             w_nonempty;
    logic             w_hazard;
    logic             w_push;
    logic             w_pop;
`ifdef DECODE_RV32M_EN
    logic             w_md;
`endif

    function automatic alu_op_t f_alu(input logic [2:0] f3, input logic alt);
        case (f3)
            3'b000:  return alt ? ALU_SUB : ALU_ADD;
            3'b001:  return ALU_SLL;
            3'b010:  return ALU_SLT;
            3'b011:  return ALU_SLTU;
            3'b100:  return ALU_XOR;
            3'b101:  return alt ? ALU_SRA : ALU_SRL;
            3'b110:  return ALU_OR;
            default: return ALU_AND;
        endcase
    endfunction

    assign w_opc = in_instr[6:0];
    assign w_f3  = in_instr[14:12];
    assign w_f7  = in_instr[31:25];

    // Decode the offered instruction into control, operand usage and legality
    always_comb begin
        w_dec     = CTRL_NOP;
        w_dec.rs1 = in_instr[19:15];
        w_dec.rs2 = in_instr[24:20];
        w_dec.rd  = in_instr[11:7];
        w_bad     = 1'b0;
        w_use1    = 1'b0;
        w_use2    = 1'b0;
`ifdef DECODE_RV32M_EN
        w_md      = 1'b0;
`endif
        case (w_opc)
            7'b0110011: begin
                w_dec.regwen = 1'b1;
                w_use1 = 1'b1;
                w_use2 = 1'b1;
                if (w_f7 == 7'b0000000) w_dec.alu_op = f_alu(w_f3, 1'b0);
                else if (w_f7 == 7'b0100000 && (w_f3 == 3'b000 || w_f3 == 3'b101)) w_dec.alu_op = f_alu(w_f3, 1'b1);
`ifdef DECODE_RV32M_EN
                else if (w_f7 == 7'b0000001) w_md = 1'b1;
`endif
                else w_bad = 1'b1;
            end
            7'b0010011: begin
                w_dec.regwen = 1'b1;
                w_dec.imm_type = IMM_I;
                w_dec.b_sel = B_IMM;
                w_dec.alu_op = f_alu(w_f3, w_f3 == 3'b101 && w_f7[5]);
                w_use1 = 1'b1;
                w_bad = (w_f3 == 3'b001 && w_f7 != 7'b0000000) || (w_f3 == 3'b101 && w_f7 != 7'b0000000 && w_f7 != 7'b0100000);
            end
            7'b0000011: begin
                w_dec.regwen = 1'b1;
                w_dec.imm_type = IMM_I;
                w_dec.b_sel = B_IMM;
                w_dec.wb_sel = WB_MEM;
                w_dec.mem_read = 1'b1;
                w_dec.mem_funct3 = w_f3;
                w_use1 = 1'b1;
                w_bad = w_f3 == 3'b011 || w_f3 == 3'b110 || w_f3 == 3'b111;
            end
            7'b0100011: begin
                w_dec.imm_type = IMM_S;
                w_dec.b_sel = B_IMM;
                w_dec.mem_write = 1'b1;
                w_dec.mem_funct3 = w_f3;
                w_use1 = 1'b1;
                w_use2 = 1'b1;
                w_bad = w_f3 > 3'b010;
            end
            7'b1100011: begin
                w_dec.imm_type = IMM_B;
                w_dec.alu_op = ALU_SUB;
                w_dec.br_type = (w_f3 == 3'b000) ? BR_EQ : (w_f3 == 3'b001) ? BR_NE : (w_f3 == 3'b100) ? BR_LT :
                                (w_f3 == 3'b101) ? BR_GE : (w_f3 == 3'b110) ? BR_LTU : BR_GEU;
                w_use1 = 1'b1;
                w_use2 = 1'b1;
                w_bad = w_f3[2:1] == 2'b01;
            end
            7'b1101111: begin
                w_dec.regwen = 1'b1;
                w_dec.imm_type = IMM_J;
                w_dec.a_sel = A_PC;
                w_dec.b_sel = B_IMM;
                w_dec.wb_sel = WB_PC4;
                w_dec.br_type = BR_JAL;
            end
            7'b1100111: begin
                w_dec.regwen = 1'b1;
                w_dec.imm_type = IMM_I;
                w_dec.b_sel = B_IMM;
                w_dec.wb_sel = WB_PC4;
                w_dec.br_type = BR_JALR;
                w_use1 = 1'b1;
                w_bad = w_f3 != 3'b000;
            end
            7'b0110111: begin
                w_dec.regwen = 1'b1;
                w_dec.imm_type = IMM_U;
                w_dec.a_sel = A_ZERO;
                w_dec.b_sel = B_IMM;
            end
            7'b0010111: begin
                w_dec.regwen = 1'b1;
                w_dec.imm_type = IMM_U;
                w_dec.a_sel = A_PC;
                w_dec.b_sel = B_IMM;
            end
            7'b0001111, 7'b1110011: begin
            end
            default: w_bad = 1'b1;
        endcase
    end

    assign w_imm = (w_dec.imm_type == IMM_I) ? {{20{in_instr[31]}}, in_instr[31:20]} :
                   (w_dec.imm_type == IMM_S) ? {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]} :
                   (w_dec.imm_type == IMM_B) ? {{19{in_instr[31]}}, in_instr[31], in_instr[7], in_instr[30:25], in_instr[11:8], 1'b0} :
                   (w_dec.imm_type == IMM_J) ? {{11{in_instr[31]}}, in_instr[31], in_instr[19:12], in_instr[20], in_instr[30:21], 1'b0} :
                   (w_dec.imm_type == IMM_U) ? {in_instr[31:12], 12'b0} : 32'b0;

    // Assemble the FIFO entry; illegal encodings keep imm/pc but carry NOP control and no operand usage
    always_comb begin
        w_in.ctrl  = w_bad ? CTRL_NOP : w_dec;
        w_in.imm   = w_imm;
        w_in.pc    = in_pc;
        w_in.ill   = w_bad;
        w_in.use1  = w_use1 && !w_bad;
        w_in.use2  = w_use2 && !w_bad;
`ifdef DECODE_RV32M_EN
        w_in.md    = w_md && !w_bad;
        w_in.md_op = w_f3;
`endif
    end

    assign w_head     = r_mem[r_rd_ptr];
    assign w_nonempty = r_count != '0;
    assign w_hazard   = ex_is_load && ex_rd != 5'd0 && !w_head.ill &&
                        ((w_head.use1 && w_head.ctrl.rs1 == ex_rd) || (w_head.use2 && w_head.ctrl.rs2 == ex_rd));
    assign in_ready   = rst_n && !flush && (r_count != L_FULL);
    assign out_valid  = rst_n && w_nonempty && !w_hazard;
    assign w_push     = in_valid && in_ready;
    assign w_pop      = out_valid && out_ready;

    assign out_ctrl      = w_nonempty ? w_head.ctrl : CTRL_NOP;
    assign out_imm       = w_nonempty ? w_head.imm : 32'b0;
    assign out_pc        = w_nonempty ? w_head.pc : '0;
    assign out_illegal   = w_nonempty && w_head.ill;
`ifdef DECODE_RV32M_EN
    assign out_is_muldiv = w_nonempty && w_head.md;
    assign out_muldiv_op = w_nonempty ? w_head.md_op : 3'b0;
`endif
    assign stall_cnt     = r_stall;

    // Entry storage needs no reset: the count alone decides what is visible
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= w_in;
    end

    // Occupancy and pointers; flush outranks push/pop, pointers wrap by width
    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            r_count  <= '0;
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
        end else begin
            r_count  <= r_count + {{AW{1'b0}}, w_push} - {{AW{1'b0}}, w_pop};
            r_wr_ptr <= w_push ? r_wr_ptr + AW'(1) : r_wr_ptr;
            r_rd_ptr <= w_pop ? r_rd_ptr + AW'(1) : r_rd_ptr;
        end
    end

    // Saturating count of cycles the head is held back by a load-use hazard
    always_ff @(posedge clk) begin
        if (!rst_n) r_stall <= '0;
        else if (w_nonempty && w_hazard && r_stall != '1) r_stall <= r_stall + 1'b1;
    end
endmodule

// File: tb/tb_decode_queue.sv
// tb_decode_queue: directed checks of decode, FIFO ordering, load-use hold, flush and reset
module tb_decode_queue;
    import control_pkg::*;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [31:0]      in_instr = 32'b0;
    logic [31:0]      in_pc = 32'b0;
    logic             flush = 1'b0;
    logic             ex_is_load = 1'b0;
    logic [4:0]       ex_rd = 5'b0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    control_signals_t out_ctrl;
    logic [31:0]      out_imm;
    logic [31:0]      out_pc;
    logic             out_illegal;
    logic [15:0]      stall_cnt;
`ifdef DECODE_RV32M_EN
    logic             out_is_muldiv;
    logic [2:0]       out_muldiv_op;
`endif
    int checks = 0;
    int errors = 0;

    decode_queue #(.PC_W(32), .DEPTH(2), .STALL_CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_instr(in_instr), .in_pc(in_pc), .flush(flush), .ex_is_load(ex_is_load),
        .ex_rd(ex_rd), .out_valid(out_valid), .out_ready(out_ready), .out_ctrl(out_ctrl),
        .out_imm(out_imm), .out_pc(out_pc), .out_illegal(out_illegal),
`ifdef DECODE_RV32M_EN
        .out_is_muldiv(out_is_muldiv), .out_muldiv_op(out_muldiv_op),
`endif
        .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] instr, input logic [31:0] pc);
        in_valid = 1'b1;
        in_instr = instr;
        in_pc = pc;
        step();
        in_valid = 1'b0;
    endtask

    logic [31:0] bad_vec [3] = '{32'h00000000, 32'h0000702F, 32'h0020A063};
    logic [31:0] dec_ins [8] = '{32'hFE20AE23, 32'hFE208CE3, 32'h008000EF, 32'h123452B7,
                                 32'h4030D093, 32'h40009093, 32'h00003083, 32'h000090E7};
    logic [31:0] dec_imm [8] = '{32'hFFFFFFFC, 32'hFFFFFFF8, 32'h00000008, 32'h12345000,
                                 32'h00000403, 32'h00000400, 32'h00000000, 32'h00000000};
    logic        dec_ill [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        step();
        step();
        check("rst_in_ready", 64'(in_ready), 64'h0);
        check("rst_out_valid", 64'(out_valid), 64'h0);
        rst_n = 1'b1;
        #1;
        check("rst_stall", 64'(stall_cnt), 64'h0);
        check("empty_ctrl", 64'(out_ctrl), 64'h0);
        check("empty_imm", 64'(out_imm), 64'h0);
        check("empty_pc", 64'(out_pc), 64'h0);
        check("empty_ill", 64'(out_illegal), 64'h0);

        out_ready = 1'b1;
        in_valid = 1'b1;
        in_instr = 32'hFFB00093;
        in_pc = 32'h100;
        #1;
        check("idle_in_ready", 64'(in_ready), 64'h1);
        check("pre_push_valid", 64'(out_valid), 64'h0);
        step();
        in_valid = 1'b0;
        check("addi_valid", 64'(out_valid), 64'h1);
        check("addi_rd", 64'(out_ctrl.rd), 64'h1);
        check("addi_regwen", 64'(out_ctrl.regwen), 64'h1);
        check("addi_imm_type", 64'(out_ctrl.imm_type), 64'(IMM_I));
        check("addi_imm", 64'(out_imm), 64'hFFFFFFFB);
        check("addi_pc", 64'(out_pc), 64'h100);
        check("addi_ill", 64'(out_illegal), 64'h0);
        step();
        check("addi_drained", 64'(out_valid), 64'h0);

        out_ready = 1'b0;
        push(32'h00100093, 32'h200);
        push(32'h00200113, 32'h204);
        in_valid = 1'b1;
        in_instr = 32'h00300193;
        in_pc = 32'h208;
        #1;
        check("full_in_ready", 64'(in_ready), 64'h0);
        check("full_head_pc", 64'(out_pc), 64'h200);
        step();
        check("full_hold_pc", 64'(out_pc), 64'h200);
        check("full_valid", 64'(out_valid), 64'h1);
        in_valid = 1'b0;
        out_ready = 1'b1;
        step();
        check("pop_order_pc", 64'(out_pc), 64'h204);
        check("pop_in_ready", 64'(in_ready), 64'h1);
        push(32'h00300193, 32'h208);
        check("pushpop_pc", 64'(out_pc), 64'h208);
        check("pushpop_imm", 64'(out_imm), 64'h3);
        check("pushpop_in_ready", 64'(in_ready), 64'h1);
        out_ready = 1'b0;
        push(32'h00400213, 32'h20C);
        check("refill_in_ready", 64'(in_ready), 64'h0);
        check("refill_head_pc", 64'(out_pc), 64'h208);
        out_ready = 1'b1;
        step();
        check("wrap_pc", 64'(out_pc), 64'h20C);
        check("wrap_rd", 64'(out_ctrl.rd), 64'h4);
        step();
        check("drain_valid", 64'(out_valid), 64'h0);
        check("drain_pc", 64'(out_pc), 64'h0);

        ex_is_load = 1'b1;
        ex_rd = 5'd2;
        push(32'h002081B3, 32'h300);
        check("haz_valid0", 64'(out_valid), 64'h0);
        step();
        check("haz_valid1", 64'(out_valid), 64'h0);
        check("haz_stall1", 64'(stall_cnt), 64'h1);
        step();
        check("haz_valid2", 64'(out_valid), 64'h0);
        step();
        check("haz_valid3", 64'(out_valid), 64'h0);
        check("haz_stall3", 64'(stall_cnt), 64'h3);
        ex_rd = 5'd1;
        #1;
        check("haz_rs1", 64'(out_valid), 64'h0);
        ex_rd = 5'd0;
        #1;
        check("haz_clear", 64'(out_valid), 64'h1);
        check("haz_rd", 64'(out_ctrl.rd), 64'h3);
        step();
        check("haz_popped", 64'(out_valid), 64'h0);
        check("haz_stall_hold", 64'(stall_cnt), 64'h3);

        ex_rd = 5'd2;
        for (int i = 0; i < 3; i++) begin
            push(bad_vec[i], 32'h400 + 32'(4 * i));
            check($sformatf("bad%0d_ill", i), 64'(out_illegal), 64'h1);
            check($sformatf("bad%0d_regwen", i), 64'(out_ctrl.regwen), 64'h0);
            check($sformatf("bad%0d_br", i), 64'(out_ctrl.br_type), 64'(BR_NONE));
            check($sformatf("bad%0d_nohaz", i), 64'(out_valid), 64'h1);
            step();
        end
        push(32'h00208063, 32'h410);
        check("beq_br", 64'(out_ctrl.br_type), 64'(BR_EQ));
        check("beq_haz", 64'(out_valid), 64'h0);
        ex_rd = 5'd0;
        #1;
        check("beq_clear", 64'(out_valid), 64'h1);
        step();
        check("bad_stall_hold", 64'(stall_cnt), 64'h3);
        ex_is_load = 1'b0;

        for (int i = 0; i < 8; i++) begin
            push(dec_ins[i], 32'h480);
            check($sformatf("dec%0d_imm", i), 64'(out_imm), 64'(dec_imm[i]));
            check($sformatf("dec%0d_ill", i), 64'(out_illegal), 64'(dec_ill[i]));
            step();
        end

        out_ready = 1'b0;
        push(32'h00100093, 32'h500);
        push(32'h00200113, 32'h504);
        flush = 1'b1;
        in_valid = 1'b1;
        in_instr = 32'h00300193;
        in_pc = 32'h508;
        #1;
        check("flush_in_ready", 64'(in_ready), 64'h0);
        step();
        flush = 1'b0;
        in_valid = 1'b0;
        check("flush_valid", 64'(out_valid), 64'h0);
        check("flush_pc", 64'(out_pc), 64'h0);
        check("flush_stall", 64'(stall_cnt), 64'h3);
        push(32'h00500293, 32'h600);
        check("flush_reuse_pc", 64'(out_pc), 64'h600);
        out_ready = 1'b1;
        step();

        push(32'h027302B3, 32'h700);
`ifdef DECODE_RV32M_EN
        check("mul_md", 64'(out_is_muldiv), 64'h1);
        check("mul_op", 64'(out_muldiv_op), 64'h0);
        check("mul_ill", 64'(out_illegal), 64'h0);
        check("mul_regwen", 64'(out_ctrl.regwen), 64'h1);
`else
        check("mul_ill", 64'(out_illegal), 64'h1);
        check("mul_regwen", 64'(out_ctrl.regwen), 64'h0);
`endif
        step();

        ex_is_load = 1'b1;
        ex_rd = 5'd1;
        out_ready = 1'b0;
        push(32'h00008093, 32'h800);
        step();
        check("mid_stall_pre", 64'(stall_cnt), 64'h4);
        rst_n = 1'b0;
        #1;
        check("mid_rst_in_ready", 64'(in_ready), 64'h0);
        check("mid_rst_valid", 64'(out_valid), 64'h0);
        step();
        rst_n = 1'b1;
        ex_is_load = 1'b0;
        #1;
        check("mid_rst_empty", 64'(out_valid), 64'h0);
        check("mid_rst_pc", 64'(out_pc), 64'h0);
        check("mid_rst_stall", 64'(stall_cnt), 64'h0);
        push(32'h00100093, 32'h900);
        check("mid_rst_reuse_pc", 64'(out_pc), 64'h900);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
